issue_queue: RTL and testbench
==============================

# issue_queue

Dual-issue instruction buffer between decode and the `issue` stage. It accepts up to two decoded `ISSUE_QUEUE_ELEMENT`s per cycle from decode and presents the oldest two entries to issue. It retires 0–2 entries per cycle as directed by `iq_pop_number`. It also supplies the in-order, wrap-around storage and occupancy accounting that the issue stage's dual-issue decisions depend on.

## Interface
- `DEPTH`, default 8: number of entries; power of two, ≥4.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `flash`, input, 1 (`bool`): pipeline flush; empties the queue.
- `stall`, input, 1 (`bool`): freezes the pop side.
- `push_data`, input, `ISSUE_QUEUE_ELEMENT [1:0]`: decoded instructions; [0] is older.
- `push_number`, input, 2: entries to enqueue this cycle (0, 1 or 2; value 3 is treated as 0).
- `push_ready`, output, 1 (`bool`): free slots ≥ 2.
- `issue_require`, output, `ISSUE_QUEUE_ELEMENT [1:0]`: oldest (slot [0]) and second-oldest (slot [1]) entries.
- `iq_size`, output, 2: min(count, 2); number of valid `issue_require` slots.
- `iq_pop_number`, input, 2: entries issued this cycle (0–2).
- `iq_count`, output, $clog2(DEPTH)+1: current occupancy, for debug/perf counters.

## Operation
- State:
  - circular array `mem[DEPTH]`;
  - `head` and `tail` pointers, $clog2(DEPTH) bits each, wrapping naturally mod DEPTH;
  - `count`, $clog2(DEPTH)+1 bits.
- Effective pop `p`:
  - 0 if `stall`;
  - otherwise min(`iq_pop_number`, `iq_size`). Over-pop is clamped and never underflows.
- Effective push `q`:
  - 0 if `push_number`==3;
  - 0 if free slots (DEPTH − count) < `push_number`. The whole request is dropped, never a partial push.
  - otherwise `push_number`.
- Push writes `push_data[0]` to `mem[tail]`. When `q`==2, it also writes `push_data[1]` to `mem[tail+1]`. Pushes are accepted while `stall` is high.
- Per-edge register updates:
  - `head` += `p`
  - `tail` += `q`
  - `count` = `count` + `q` − `p`
  - Push and pop in the same cycle are legal. A full queue with pop 2 / push 2 stays full.
- `flash` has priority over push and pop: `head`, `tail` and `count` go to 0, and that cycle's push is discarded. `mem` contents are not cleared.
- `rst` has the same effect as `flash`, and overrides it.
- Outputs:
  - `issue_require[0]` = `mem[head]` when count ≥ 1, else all-zero.
  - `issue_require[1]` = `mem[head+1]` (with wrap) when count ≥ 2, else all-zero.
  - `push_ready` = (DEPTH − count ≥ 2). It is conservative: same-cycle pops are not credited.

## Timing
- Reset values: `iq_size`=0, `iq_count`=0, `issue_require`=all-zero, `push_ready`=1.
- `issue_require`, `iq_size`, `push_ready` and `iq_count` are combinational from registered state only. There is no combinational path from `push_*` or `iq_pop_number` to any output.
- Push latency is 1 cycle: an entry pushed at edge N is visible on `issue_require` in cycle N+1. There is no empty-queue bypass.
- Pop takes effect at the edge. In the following cycle the next entries are shifted into slots [0] and [1].
- During `flash`, outputs still reflect the pre-flush state. They read empty from the next cycle on.
- Boundaries:
  - Pointer wrap DEPTH−1 → 0 must keep `issue_require[1]` correct.
  - At count==DEPTH, any push is dropped.
  - At count==DEPTH−1, a push of 1 is accepted and a push of 2 is dropped.

## Structure
- Uses `ISSUE_QUEUE_ELEMENT`, `bool`, `` `true `` / `` `false `` from `defines.svh`.
- Add `` `define IQ_DEPTH 8 `` to `defines.svh` so decode and issue can size against it.
- One natural sub-module, `iq_storage`: a DEPTH-entry register array with two write ports and two asynchronous read ports.
- Pointer, count and clamp logic stay in `issue_queue`.

## Test plan
- Reset, then push 2 (A, B) → next cycle `iq_size`=2, slot[0]=A, slot[1]=B, `iq_count`=2. Pop 1 → next cycle slot[0]=B, slot[1]=0, `iq_size`=1.
- Fill to 8 with pushes of 2 → `push_ready`=0 once count ≥7. Push 2 at count 8 → dropped, count stays 8. Simultaneous pop 2 + push 2 at count 8 → count 8, order preserved.
- Cycle 20 entries through DEPTH=8 with push 2 / pop 2 each cycle → FIFO order intact across `head`/`tail` wrap, including slot[1] at `head`=7.
- `stall`=1 with `iq_pop_number`=2 and push 1 → `head` unchanged, count +1. `iq_pop_number`=2 with count 1 → pops exactly 1, count 0.
- `flash` together with push 2 and pop 1 at count 5 → next cycle count 0, `iq_size`=0, outputs zero. Following push 1 (C) → C at slot[0].
- `rst` asserted mid-stream with count 6 → next cycle all outputs equal their reset values.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// issue_queue_pkg: shared entry type, boolean type and default depth for decode/issue sizing.
package issue_queue_pkg;
    typedef logic bool;
    localparam bool TRUE = 1'b1;
    localparam bool FALSE = 1'b0;
    localparam int IQ_DEPTH = 8;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ISSUE_QUEUE_ELEMENT;
endpackage

// File: rtl/iq_storage.sv
// iq_storage: DEPTH-entry register array, two write ports, two asynchronous read ports.
module iq_storage
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we0,
    input  logic [AW-1:0]      wa0,
    input  ISSUE_QUEUE_ELEMENT wd0,
    input  logic               we1,
    input  logic [AW-1:0]      wa1,
    input  ISSUE_QUEUE_ELEMENT wd1,
    input  logic [AW-1:0]      ra0,
    input  logic [AW-1:0]      ra1,
    output ISSUE_QUEUE_ELEMENT rd0,
    output ISSUE_QUEUE_ELEMENT rd1
);
    ISSUE_QUEUE_ELEMENT mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we0) mem[wa0] <= wd0;
        if (we1) mem[wa1] <= wd1;
    end
    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];
endmodule

// File: rtl/issue_queue.sv
// issue_queue: dual-push, dual-issue in-order circular buffer between decode and issue.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flash,
    input  logic                     stall,
    input  ISSUE_QUEUE_ELEMENT [1:0] push_data,
    input  logic [1:0]               push_number,
    output logic                     push_ready,
    output ISSUE_QUEUE_ELEMENT [1:0] issue_require,
    output logic [1:0]               iq_size,
    input  logic [1:0]               iq_pop_number,
    output logic [AW:0]              iq_count
);
    logic [AW-1:0] head, tail;
    logic [AW:0] count, free;
    logic [1:0] p, q;
    logic clear;
    ISSUE_QUEUE_ELEMENT rd0, rd1;
    assign clear = rst || flash;
    assign free = (AW+1)'(DEPTH) - count;
    assign iq_size = count >= 2 ? 2'd2 : count[1:0];
    // Over-pop clamps to what is visible; oversize pushes are dropped whole.
    assign p = stall ? 2'd0 : (iq_pop_number > iq_size ? iq_size : iq_pop_number);
    assign q = (push_number == 2'd3 || free < (AW+1)'(push_number)) ? 2'd0 : push_number;
    iq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk(clk),
        .we0(!clear && q != 2'd0),
        .wa0(tail),
        .wd0(push_data[0]),
        .we1(!clear && q == 2'd2),
        .wa1(tail + 1'b1),
        .wd1(push_data[1]),
        .ra0(head),
        .ra1(head + 1'b1),
        .rd0(rd0),
        .rd1(rd1)
    );
    always_ff @(posedge clk) begin
        if (clear) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            head <= head + AW'(p);
            tail <= tail + AW'(q);
            count <= count + (AW+1)'(q) - (AW+1)'(p);
        end
    end
    assign issue_require[0] = count >= 1 ? rd0 : '0;
    assign issue_require[1] = count >= 2 ? rd1 : '0;
    assign push_ready = free >= 2;
    assign iq_count = count;
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed steps against a queue-based scoreboard of expected entries.
module tb_issue_queue;
    import issue_queue_pkg::*;
    localparam int DEPTH = 8;
    logic clk = 0, rst = 1, flash = 0, stall = 0;
    ISSUE_QUEUE_ELEMENT [1:0] push_data = '0;
    logic [1:0] push_number = 0, iq_pop_number = 0, iq_size;
    logic push_ready;
    ISSUE_QUEUE_ELEMENT [1:0] issue_require;
    logic [$clog2(DEPTH):0] iq_count;
    ISSUE_QUEUE_ELEMENT model[$];
    int n_cmp = 0, n_bad = 0, seq = 0;

    issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flash(flash), .stall(stall),
        .push_data(push_data), .push_number(push_number), .push_ready(push_ready),
        .issue_require(issue_require), .iq_size(iq_size),
        .iq_pop_number(iq_pop_number), .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    function automatic ISSUE_QUEUE_ELEMENT mk(input int n);
        ISSUE_QUEUE_ELEMENT e;
        e.pc = 32'h1000 + 32'(n);
        e.inst = 32'hA500_0000 ^ 32'(n);
        return e;
    endfunction

    task automatic chk_e(input string tag, input ISSUE_QUEUE_ELEMENT obs, input ISSUE_QUEUE_ELEMENT exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = model.size();
        chk_i("iq_count", int'(iq_count), sz);
        chk_i("iq_size", int'(iq_size), sz > 2 ? 2 : sz);
        chk_i("push_ready", int'(push_ready), (DEPTH - sz >= 2) ? 1 : 0);
        if (sz >= 1) chk_e("slot0", issue_require[0], model[0]);
        else chk_e("slot0_empty", issue_require[0], '0);
        if (sz >= 2) chk_e("slot1", issue_require[1], model[1]);
        else chk_e("slot1_empty", issue_require[1], '0);
    endtask

    task automatic cycle(input int pn, input int pop, input bit st = 0, input bit fl = 0, input bit rs = 0);
        ISSUE_QUEUE_ELEMENT d0, d1;
        int sz, p, q;
        d0 = mk(seq);
        d1 = mk(seq + 1);
        seq += 2;
        push_data[0] = d0;
        push_data[1] = d1;
        push_number = pn[1:0];
        iq_pop_number = pop[1:0];
        stall = st;
        flash = fl;
        rst = rs;
        sz = model.size() > 2 ? 2 : model.size();
        p = st ? 0 : (pop > sz ? sz : pop);
        q = (pn == 3 || DEPTH - model.size() < pn) ? 0 : pn;
        // Entries leaving at this edge must be the ones currently presented.
        for (int i = 0; i < p; i++) chk_e("popped", issue_require[i], model[i]);
        @(posedge clk);
        #1;
        if (rs || fl) model.delete();
        else begin
            repeat (p) void'(model.pop_front());
            if (q >= 1) model.push_back(d0);
            if (q == 2) model.push_back(d1);
        end
        check_state();
    endtask

    initial begin
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0);
        cycle(2, 0);
        cycle(0, 1);
        cycle(0, 1);
        repeat (4) cycle(2, 0);
        cycle(2, 0);
        cycle(2, 2);
        cycle(1, 0);
        cycle(0, 1);
        cycle(2, 0);
        cycle(1, 0);
        cycle(0, 3);
        repeat (3) cycle(0, 2);
        cycle(2, 0);
        repeat (10) cycle(2, 2);
        cycle(0, 2);
        cycle(2, 0);
        cycle(1, 2, 1);
        cycle(0, 2);
        cycle(0, 2);
        cycle(3, 0);
        repeat (2) cycle(2, 0);
        cycle(1, 0);
        cycle(2, 1, 0, 1);
        cycle(1, 0);
        repeat (2) cycle(2, 0);
        cycle(1, 0);
        cycle(2, 1, 0, 0, 1);
        cycle(0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
